// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronized active-low rows,
// full-scan debounce and a press/release event FSM producing {row,col} key codes.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       fastclk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_release
);

    localparam int                 DWELL_W    = $clog2(SCAN_DIV);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [3:0]         STABLE_MAX = 4'(DEBOUNCE_SCANS);

    // state        | meaning
    // ST_IDLE      | no key accepted, waiting for a single debounced key
    // ST_PRESSED   | one key accepted and still held
    // ST_WAIT_REL  | ambiguous or changed pattern, waiting for a full release
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    logic [3:0]         row_sync1;
    logic [3:0]         row_sync2;
    logic [3:0]         pressed;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         col_idx;
    logic               dwell_last;
    logic               scan_end;
    logic [15:0]        snapshot;
    logic [15:0]        snap_next;
    logic [15:0]        prev_snapshot;
    logic [15:0]        debounced;
    logic [3:0]         stable_cnt;
    logic [3:0]         stable_next;
    logic               update;

    state_t             state;
    state_t             state_next;
    logic [15:0]        held_pattern;
    logic [15:0]        pattern_next;
    logic [3:0]         code_next;
    logic [3:0]         hit_code;
    logic               one_key;
    logic               valid_next;
    logic               release_next;
    logic               held_next;

    assign pressed    = ~row_sync2;
    assign dwell_last = (dwell == DWELL_LAST);
    assign scan_end   = dwell_last && (col_idx == 2'd3);

    always_comb begin
        col_n          = 4'b1111;
        col_n[col_idx] = 1'b0;
    end

    // Snapshot bit index is col*4 + row, so a column occupies one nibble.
    always_comb begin
        snap_next                        = snapshot;
        snap_next[{col_idx, 2'b00} +: 4] = pressed;
    end

    always_comb begin
        stable_next = 4'd1;
        if (snap_next == prev_snapshot) begin
            stable_next = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge fastclk) begin
        if (reset) begin
            row_sync1     <= 4'hF;
            row_sync2     <= 4'hF;
            dwell         <= '0;
            col_idx       <= 2'd0;
            snapshot      <= 16'h0;
            prev_snapshot <= 16'h0;
            debounced     <= 16'h0;
            stable_cnt    <= 4'd0;
            update        <= 1'b0;
        end else begin
            row_sync1 <= row_n;
            row_sync2 <= row_sync1;
            update    <= 1'b0;
            if (dwell_last) begin
                dwell    <= '0;
                col_idx  <= col_idx + 2'd1;
                snapshot <= snap_next;
            end else begin
                dwell <= dwell + DWELL_ONE;
            end
            if (scan_end) begin
                prev_snapshot <= snap_next;
                stable_cnt    <= stable_next;
                // Accept only on the transition into the stable state, not while saturated.
                if ((stable_next == STABLE_MAX) && (stable_cnt != STABLE_MAX)) begin
                    debounced <= snap_next;
                    update    <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (debounced[i]) begin
                hit_code = {i[1:0], i[3:2]};
            end
        end
        one_key = (debounced != 16'h0) && ((debounced & (debounced - 16'h1)) == 16'h0);
    end

    always_comb begin
        state_next   = state;
        pattern_next = held_pattern;
        code_next    = key_code;
        valid_next   = 1'b0;
        release_next = 1'b0;
        held_next    = key_held;
        if (update) begin
            case (state)
                ST_IDLE: begin
                    if (one_key) begin
                        code_next    = hit_code;
                        pattern_next = debounced;
                        valid_next   = 1'b1;
                        held_next    = 1'b1;
                        state_next   = ST_PRESSED;
                    end else if (debounced != 16'h0) begin
                        state_next = ST_WAIT_REL;
                    end
                end
                ST_PRESSED: begin
                    if (debounced == 16'h0) begin
                        release_next = 1'b1;
                        held_next    = 1'b0;
                        state_next   = ST_IDLE;
                    end else if (debounced != held_pattern) begin
                        release_next = 1'b1;
                        held_next    = 1'b0;
                        state_next   = ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (debounced == 16'h0) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    held_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge fastclk) begin
        if (reset) begin
            state        <= ST_IDLE;
            held_pattern <= 16'h0;
            key_code     <= 4'h0;
            key_valid    <= 1'b0;
            key_held     <= 1'b0;
            key_release  <= 1'b0;
        end else begin
            state        <= state_next;
            held_pattern <= pattern_next;
            key_code     <= code_next;
            key_valid    <= valid_next;
            key_held     <= held_next;
            key_release  <= release_next;
        end
    end

endmodule
